retire_trace_buffer: RTL and testbench

RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

---
 rtl/trace_pkg.sv | 22 ++
 rtl/trace_fifo.sv | 60 ++++++
 rtl/retire_trace_buffer.sv | 119 +++++++++++
 tb/tb_retire_trace_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared state encodings and trace-entry field widths
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_POST    = 2'd2,
        ST_STOPPED = 2'd3
    } trace_state_e;

    localparam int INSTR_W = 32;
    localparam int RD_W    = 5;
    localparam int SEQ_W   = 32;
    localparam int POST_W  = 8;
    localparam int DROP_W  = 16;

    // Packed entry layout: {pc, instr, we, rd, wdata, seq}
    function automatic int entry_width(input int xlen);
        return 2 * xlen + INSTR_W + 1 + RD_W + SEQ_W;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through storage with pointers and occupancy
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Full is judged before any same-cycle pop, so a push into a full FIFO is lost
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - triggered retire-trace capture with FWFT readout
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    retire_valid,
    input  logic [XLEN-1:0]         retire_pc,
    input  logic [INSTR_W-1:0]      retire_instr,
    input  logic                    retire_we,
    input  logic [RD_W-1:0]         retire_rd,
    input  logic [XLEN-1:0]         retire_wdata,
    input  logic                    start,
    input  logic                    clear,
    input  logic [XLEN-1:0]         trig_pc,
    input  logic [POST_W-1:0]       post_count,
    input  logic                    trace_ready,
    output logic                    trace_valid,
    output logic [XLEN-1:0]         trace_pc,
    output logic [INSTR_W-1:0]      trace_instr,
    output logic                    trace_we,
    output logic [RD_W-1:0]         trace_rd,
    output logic [XLEN-1:0]         trace_wdata,
    output logic [SEQ_W-1:0]        trace_seq,
    output logic [1:0]              state,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic [DROP_W-1:0]       drop_count
);
    localparam int EW = entry_width(XLEN);

    trace_state_e      state_q, state_d;
    logic [SEQ_W-1:0]  seq_ctr, seq_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [POST_W-1:0] post_ctr, post_d;
    logic              capture;
    logic              push;
    logic              empty;
    logic [EW-1:0]     head;

    assign capture = retire_valid && (state_q == ST_ARMED || state_q == ST_POST);
    assign push    = capture && !full;

    trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (push),
        .pop   (trace_ready),
        .wdata ({retire_pc, retire_instr, retire_we, retire_rd, retire_wdata, seq_ctr}),
        .rdata (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign {trace_pc, trace_instr, trace_we, trace_rd, trace_wdata, trace_seq} = head;
    assign trace_valid = !empty;
    assign state       = state_q;
    assign drop_count  = drop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            seq_ctr  <= '0;
            drop_q   <= '0;
            post_ctr <= '0;
        end else begin
            state_q  <= state_d;
            seq_ctr  <= seq_d;
            drop_q   <= drop_d;
            post_ctr <= post_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seq_d   = seq_ctr;
        drop_d  = drop_q;
        post_d  = post_ctr;
        if (clear) begin
            state_d = ST_IDLE;
            seq_d   = '0;
            drop_d  = '0;
            post_d  = '0;
        end else begin
            // Sequence advances on dropped attempts too, leaving visible gaps
            if (capture) seq_d = seq_ctr + SEQ_W'(1);
            if (capture && full && drop_q != '1) drop_d = drop_q + DROP_W'(1);
            case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (retire_valid && retire_pc == trig_pc) begin
                        if (post_count == '0) begin
                            state_d = ST_STOPPED;
                        end else begin
                            post_d  = post_count;
                            state_d = ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (retire_valid) begin
                        post_d = post_ctr - POST_W'(1);
                        if (post_ctr == POST_W'(1)) state_d = ST_STOPPED;
                    end
                end
                ST_STOPPED: state_d = ST_STOPPED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - directed scoreboard bench for retire_trace_buffer
module tb_retire_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        retire_valid;
    logic [63:0] retire_pc;
    logic [31:0] retire_instr;
    logic        retire_we;
    logic [4:0]  retire_rd;
    logic [63:0] retire_wdata;
    logic        start;
    logic        clear;
    logic [63:0] trig_pc;
    logic [7:0]  post_count;
    logic        trace_ready;
    logic        trace_valid;
    logic [63:0] trace_pc;
    logic [31:0] trace_instr;
    logic        trace_we;
    logic [4:0]  trace_rd;
    logic [63:0] trace_wdata;
    logic [31:0] trace_seq;
    logic [1:0]  state;
    logic [4:0]  count;
    logic        full;
    logic [15:0] drop_count;

    retire_trace_buffer #(.XLEN(64), .DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_instr (retire_instr),
        .retire_we    (retire_we),
        .retire_rd    (retire_rd),
        .retire_wdata (retire_wdata),
        .start        (start),
        .clear        (clear),
        .trig_pc      (trig_pc),
        .post_count   (post_count),
        .trace_ready  (trace_ready),
        .trace_valid  (trace_valid),
        .trace_pc     (trace_pc),
        .trace_instr  (trace_instr),
        .trace_we     (trace_we),
        .trace_rd     (trace_rd),
        .trace_wdata  (trace_wdata),
        .trace_seq    (trace_seq),
        .state        (state),
        .count        (count),
        .full         (full),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic [31:0] seq;
    } ent_t;

    ent_t        m_q[$];
    int          m_state;
    logic [31:0] m_seq;
    logic [15:0] m_drop;
    logic [7:0]  m_post;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_state = 0;
        m_seq   = '0;
        m_drop  = '0;
        m_post  = '0;
    endtask

    task automatic cycle(input logic rv, input logic [63:0] pc, input logic st,
                         input logic clr, input logic rdy);
        ent_t e;
        logic full_pre;
        retire_valid = rv;
        retire_pc    = pc;
        retire_instr = pc[31:0] ^ 32'h00A5_0013;
        retire_we    = pc[2];
        retire_rd    = pc[6:2];
        retire_wdata = {pc[31:0], ~pc[31:0]};
        start        = st;
        clear        = clr;
        trace_ready  = rdy;
        #1;
        if (clr) begin
            model_reset();
        end else begin
            full_pre = (m_q.size() == 16);
            if (rdy && m_q.size() > 0) begin
                check("pop_pc",    trace_pc,    m_q[0].pc);
                check("pop_instr", trace_instr, m_q[0].instr);
                check("pop_we",    trace_we,    m_q[0].we);
                check("pop_rd",    trace_rd,    m_q[0].rd);
                check("pop_wdata", trace_wdata, m_q[0].wdata);
                check("pop_seq",   trace_seq,   m_q[0].seq);
                void'(m_q.pop_front());
            end
            if (rv && (m_state == 1 || m_state == 2)) begin
                if (!full_pre) begin
                    e.pc = pc; e.instr = retire_instr; e.we = retire_we;
                    e.rd = retire_rd; e.wdata = retire_wdata; e.seq = m_seq;
                    m_q.push_back(e);
                end else if (m_drop != 16'hFFFF) begin
                    m_drop = m_drop + 16'd1;
                end
                m_seq = m_seq + 32'd1;
            end
            case (m_state)
                0: if (st) m_state = 1;
                1: if (rv && pc == trig_pc) begin
                       if (post_count == 8'd0) m_state = 3;
                       else begin m_post = post_count; m_state = 2; end
                   end
                2: if (rv) begin
                       m_post = m_post - 8'd1;
                       if (m_post == 8'd0) m_state = 3;
                   end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        check("state",       state,       m_state);
        check("count",       count,       m_q.size());
        check("full",        full,        m_q.size() == 16);
        check("drop_count",  drop_count,  m_drop);
        check("trace_valid", trace_valid, m_q.size() > 0);
        if (m_q.size() > 0) check("head_seq", trace_seq, m_q[0].seq);
        else                check("empty_pc", trace_pc,  64'd0);
    endtask

    initial begin
        reset = 1'b1;
        retire_valid = 0; retire_pc = 0; retire_instr = 0; retire_we = 0;
        retire_rd = 0; retire_wdata = 0; start = 0; clear = 0;
        trig_pc = 0; post_count = 0; trace_ready = 0;
        model_reset();
        #2;
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_full",  full, 0);
        check("rst_valid", trace_valid, 0);
        check("rst_pc",    trace_pc, 0);
        check("rst_drop",  drop_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Trigger at 0x10 with two post entries; start arrives just before 0x10
        trig_pc = 64'h10; post_count = 8'd2;
        cycle(1, 64'h0, 0, 0, 0);
        cycle(1, 64'h4, 0, 0, 0);
        cycle(1, 64'h8, 0, 0, 0);
        cycle(1, 64'hc, 1, 0, 0);
        cycle(1, 64'h10, 0, 0, 0);
        cycle(1, 64'h14, 0, 0, 0);
        cycle(1, 64'h18, 0, 0, 0);
        cycle(1, 64'h1c, 0, 0, 0);
        cycle(1, 64'h10, 0, 0, 0);
        check("t1_state", state, 3);
        check("t1_count", count, 3);
        check("t1_head_pc", trace_pc, 64'h10);
        check("t1_head_seq", trace_seq, 0);
        for (int i = 0; i < 3; i++) cycle(1, 64'h24 + 64'(4 * i), 0, 0, 1);
        check("t1_drained", trace_valid, 0);
        cycle(0, 64'h0, 1, 0, 0);
        check("t1_start_ignored", state, 3);
        cycle(0, 64'h0, 0, 1, 0);

        // Trigger never hit: fill and overflow
        trig_pc = 64'hFFFF_FFFF_FFFF_FFF0; post_count = 8'd3;
        cycle(0, 64'h0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 64'h1000 + 64'(4 * i), 0, 0, 0);
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);
        check("ovf_drop", drop_count, 4);
        check("ovf_head_seq", trace_seq, 0);
        check("ovf_head_pc", trace_pc, 64'h1000);

        // Pop and push together while full: push is lost
        cycle(1, 64'h1050, 0, 0, 1);
        check("fullpop_count", count, 15);
        check("fullpop_drop", drop_count, 5);
        check("fullpop_head_seq", trace_seq, 1);
        for (int i = 0; i < 40; i++)
            cycle(1'($urandom_range(0, 1)), 64'h2000 + 64'(4 * i), 0, 0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 18; i++) cycle(0, 64'h0, 0, 0, 1);
        check("mix_empty", trace_valid, 0);
        cycle(0, 64'h0, 0, 1, 0);

        // post_count of zero stops right on the trigger entry
        trig_pc = 64'h100; post_count = 8'd0;
        cycle(0, 64'h0, 1, 0, 0);
        cycle(1, 64'h100, 0, 0, 0);
        check("p0_state", state, 3);
        check("p0_count", count, 1);
        cycle(1, 64'h104, 0, 0, 0);
        check("p0_count_hold", count, 1);
        cycle(0, 64'h0, 0, 1, 0);

        // Clear in POST with five entries, concurrent push and pop discarded
        trig_pc = 64'h200; post_count = 8'd10;
        cycle(0, 64'h0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 64'h1f8 + 64'(4 * i), 0, 0, 0);
        check("clr_pre_state", state, 2);
        check("clr_pre_count", count, 5);
        cycle(1, 64'h20c, 0, 1, 1);
        check("clr_state", state, 0);
        check("clr_count", count, 0);
        check("clr_valid", trace_valid, 0);
        cycle(0, 64'h0, 1, 0, 0);
        cycle(1, 64'h300, 0, 0, 0);
        check("clr_seq_restart", trace_seq, 0);

        // Asynchronous reset between edges during capture
        trig_pc = 64'h400; post_count = 8'd5;
        cycle(1, 64'h400, 0, 0, 0);
        cycle(1, 64'h404, 0, 0, 0);
        check("ar_pre_state", state, 2);
        #2;
        reset = 1'b1;
        #1;
        check("ar_state", state, 0);
        check("ar_count", count, 0);
        check("ar_full", full, 0);
        check("ar_valid", trace_valid, 0);
        check("ar_pc", trace_pc, 0);
        check("ar_seq", trace_seq, 0);
        check("ar_drop", drop_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1, 64'h408, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
